// File: rtl/l2_pkg.sv
// Shared types and sizing helpers for the unified round-robin L2.
package l2_pkg;

    localparam int unsigned DEF_ADDR_W = 28;
    localparam int unsigned DEF_LINE_W = 128;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StWriteback,
        StAllocate,
        StRespond
    } state_e;

    function automatic int unsigned idx_w(input int unsigned nsets);
        return $clog2(nsets);
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned nsets);
        return addr_w - $clog2(nsets);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester after last_grant (mod NPORT) wins.
module rr_arbiter #(
    parameter int unsigned NPORT = 2,
    localparam int unsigned GW = $clog2(NPORT)
) (
    input  logic [NPORT-1:0] req,
    input  logic [GW-1:0]    last,
    output logic [NPORT-1:0] grant,
    output logic [GW-1:0]    grant_idx,
    output logic             any
);

    localparam logic [GW:0] NP = (GW+1)'(NPORT);

    logic [GW:0] cand;

    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int i = 1; i <= int'(NPORT); i++) begin
            cand = {1'b0, last} + (GW+1)'(i);
            if (cand >= NP) cand = cand - NP;
            if (!any && req[cand[GW-1:0]]) begin
                any       = 1'b1;
                grant_idx = cand[GW-1:0];
            end
        end
        grant = any ? (NPORT'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/l2cache_rr.sv
// Unified direct-mapped write-back L2 shared by NPORT L1s via round-robin arbitration.
module l2cache_rr
    import l2_pkg::*;
#(
    parameter int unsigned NPORT  = 2,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned LINE_W = DEF_LINE_W,
    parameter int unsigned NSETS  = 16,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      proc_reset,
    input  logic [NPORT-1:0]          req_read,
    input  logic [NPORT-1:0]          req_write,
    input  logic [NPORT*ADDR_W-1:0]   req_addr,
    input  logic [NPORT*LINE_W-1:0]   req_wdata,
    output logic [NPORT*LINE_W-1:0]   req_rdata,
    output logic [NPORT-1:0]          req_ready,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [LINE_W-1:0]         mem_wdata,
    input  logic [LINE_W-1:0]         mem_rdata,
    input  logic                      mem_ready,
    output logic [CNT_W-1:0]          hit_cnt,
    output logic [CNT_W-1:0]          miss_cnt
);

    localparam int unsigned GW = $clog2(NPORT);
    localparam int unsigned IW = idx_w(NSETS);
    localparam int unsigned TW = tag_w(ADDR_W, NSETS);

    logic [ADDR_W-1:0] addr_v  [NPORT];
    logic [LINE_W-1:0] wdata_v [NPORT];
    logic [LINE_W-1:0] rdata_q [NPORT];

    for (genvar i = 0; i < int'(NPORT); i++) begin : g_port
        assign addr_v[i]                      = req_addr[i*ADDR_W +: ADDR_W];
        assign wdata_v[i]                     = req_wdata[i*LINE_W +: LINE_W];
        assign req_rdata[i*LINE_W +: LINE_W]  = rdata_q[i];
    end

    state_e            state_q;
    logic [NSETS-1:0]  valid_q, dirty_q;
    logic [TW-1:0]     tag_q  [NSETS];
    logic [LINE_W-1:0] data_q [NSETS];
    logic [GW-1:0]     g_q, last_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q, mem_addr_q;
    logic [LINE_W-1:0] wdata_q, mem_wdata_q;
    logic [NPORT-1:0]  ready_q;
    logic              mem_read_q, mem_write_q;
    logic [CNT_W-1:0]  hit_q, miss_q;

    logic [NPORT-1:0] gnt;
    logic [GW-1:0]    gnt_idx;
    logic             gnt_any;

    rr_arbiter #(.NPORT(NPORT)) u_arb (
        .req       (req_read | req_write),
        .last      (last_q),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .any       (gnt_any)
    );

    logic [IW-1:0] idx;
    logic [TW-1:0] atag;
    logic          hit;

    assign idx  = addr_q[IW-1:0];
    assign atag = addr_q[ADDR_W-1:IW];
    assign hit  = valid_q[idx] && (tag_q[idx] == atag);

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q     <= StIdle;
            valid_q     <= '0;
            dirty_q     <= '0;
            last_q      <= GW'(NPORT - 1);
            g_q         <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ready_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
            for (int i = 0; i < int'(NPORT); i++) rdata_q[i] <= '0;
        end else begin
            ready_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (gnt_any) begin
                        g_q     <= gnt_idx;
                        wr_q    <= |(req_write & gnt);  // write wins over read on one port
                        addr_q  <= addr_v[gnt_idx];
                        wdata_q <= wdata_v[gnt_idx];
                        state_q <= StLookup;
                    end
                end
                StLookup: begin
                    if (hit) begin
                        if (!(&hit_q)) hit_q <= hit_q + CNT_W'(1);
                        if (wr_q) begin
                            data_q[idx]  <= wdata_q;
                            dirty_q[idx] <= 1'b1;
                        end else begin
                            rdata_q[g_q] <= data_q[idx];
                        end
                        ready_q[g_q] <= 1'b1;
                        state_q      <= StRespond;
                    end else begin
                        if (!(&miss_q)) miss_q <= miss_q + CNT_W'(1);
                        if (valid_q[idx] && dirty_q[idx]) begin
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {tag_q[idx], idx};
                            mem_wdata_q <= data_q[idx];
                            state_q     <= StWriteback;
                        end else if (!wr_q) begin
                            mem_read_q <= 1'b1;
                            mem_addr_q <= addr_q;
                            state_q    <= StAllocate;
                        end else begin
                            // Full-line write: no fetch needed.
                            valid_q[idx] <= 1'b1;
                            dirty_q[idx] <= 1'b1;
                            tag_q[idx]   <= atag;
                            data_q[idx]  <= wdata_q;
                            ready_q[g_q] <= 1'b1;
                            state_q      <= StRespond;
                        end
                    end
                end
                StWriteback: begin
                    if (mem_ready) begin
                        mem_write_q  <= 1'b0;
                        mem_wdata_q  <= '0;
                        dirty_q[idx] <= 1'b0;
                        if (wr_q) begin
                            valid_q[idx] <= 1'b1;
                            dirty_q[idx] <= 1'b1;
                            tag_q[idx]   <= atag;
                            data_q[idx]  <= wdata_q;
                            mem_addr_q   <= '0;
                            ready_q[g_q] <= 1'b1;
                            state_q      <= StRespond;
                        end else begin
                            mem_read_q <= 1'b1;
                            mem_addr_q <= addr_q;
                            state_q    <= StAllocate;
                        end
                    end
                end
                StAllocate: begin
                    if (mem_ready) begin
                        mem_read_q   <= 1'b0;
                        mem_addr_q   <= '0;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        tag_q[idx]   <= atag;
                        data_q[idx]  <= mem_rdata;
                        rdata_q[g_q] <= mem_rdata;
                        ready_q[g_q] <= 1'b1;
                        state_q      <= StRespond;
                    end
                end
                StRespond: begin
                    last_q  <= g_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign hit_cnt   = hit_q;
    assign miss_cnt  = miss_q;

endmodule

// File: tb/tb_l2cache_rr.sv
// Self-checking bench for l2cache_rr: scoreboard per port plus a behavioural memory.
module tb_l2cache_rr;

    localparam int unsigned NPORT  = 2;
    localparam int unsigned ADDR_W = 28;
    localparam int unsigned LINE_W = 128;
    localparam int unsigned NSETS  = 16;
    localparam int unsigned CNT_W  = 32;

    logic                     clk = 1'b0;
    logic                     proc_reset;
    logic [NPORT-1:0]         req_read, req_write;
    logic [NPORT*ADDR_W-1:0]  req_addr;
    logic [NPORT*LINE_W-1:0]  req_wdata;
    logic [NPORT*LINE_W-1:0]  req_rdata;
    logic [NPORT-1:0]         req_ready;
    logic                     mem_read, mem_write;
    logic [ADDR_W-1:0]        mem_addr;
    logic [LINE_W-1:0]        mem_wdata;
    logic [LINE_W-1:0]        mem_rdata;
    logic                     mem_ready;
    logic [CNT_W-1:0]         hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    l2cache_rr #(
        .NPORT(NPORT), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .NSETS(NSETS), .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rdata  (req_rdata),
        .req_ready  (req_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    typedef struct {
        bit                is_read;
        logic [LINE_W-1:0] data;
    } sb_t;

    typedef struct {
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } mop_t;

    sb_t               sb_q [NPORT][$];
    mop_t              mem_log[$];
    logic [LINE_W-1:0] mem_img [logic [ADDR_W-1:0]];
    logic [LINE_W-1:0] ref_mem [logic [ADDR_W-1:0]];

    int checks    = 0;
    int errors    = 0;
    int mem_delay = 3;
    int wcnt      = 0;

    function automatic logic [LINE_W-1:0] default_line(input logic [ADDR_W-1:0] a);
        if (a == 28'h0000010) return {16{8'hA5}};
        return {4{4'hC, a}};
    endfunction

    function automatic logic [LINE_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return default_line(a);
    endfunction

    // Behavioural memory: answers after mem_delay cycles of a held request.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (mem_read || mem_write) begin
                wcnt++;
                if (wcnt >= mem_delay) begin
                    if (mem_write) begin
                        mem_img[mem_addr] = mem_wdata;
                        mem_log.push_back('{wr: 1'b1, addr: mem_addr, data: mem_wdata});
                    end else begin
                        mem_rdata = mem_img.exists(mem_addr) ? mem_img[mem_addr]
                                                             : default_line(mem_addr);
                        mem_log.push_back('{wr: 1'b0, addr: mem_addr, data: mem_rdata});
                    end
                    mem_ready = 1'b1;
                    wcnt      = 0;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Scoreboard monitor: every req_ready pulse must match a pushed expectation.
    initial begin
        sb_t it;
        forever begin
            @(negedge clk);
            for (int p = 0; p < int'(NPORT); p++) begin
                if (req_ready[p]) begin
                    checks++;
                    if (sb_q[p].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_ready port %0d got 1 required 0", p);
                    end else begin
                        it = sb_q[p].pop_front();
                        if (it.is_read && req_rdata[p*LINE_W +: LINE_W] !== it.data) begin
                            errors++;
                            $display("FAIL rdata port %0d got %h required %h", p,
                                     req_rdata[p*LINE_W +: LINE_W], it.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        proc_reset = 1'b1;
        req_read   = '0;
        req_write  = '0;
        repeat (2) @(negedge clk);
        proc_reset = 1'b0;
        for (int p = 0; p < int'(NPORT); p++) sb_q[p].delete();
        mem_log.delete();
    endtask

    task automatic do_req(input int p, input bit wr, input logic [ADDR_W-1:0] a,
                          input logic [LINE_W-1:0] wd, output int cyc);
        sb_t it;
        @(negedge clk);
        req_addr[p*ADDR_W +: ADDR_W]  = a;
        req_wdata[p*LINE_W +: LINE_W] = wd;
        req_read[p]  = !wr;
        req_write[p] = wr;
        if (wr) begin
            ref_mem[a] = wd;
            it.is_read = 1'b0;
            it.data    = wd;
        end else begin
            it.is_read = 1'b1;
            it.data    = ref_read(a);
        end
        sb_q[p].push_back(it);
        cyc = -1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (req_ready[p]) begin
                cyc = c;
                break;
            end
        end
        req_read[p]  = 1'b0;
        req_write[p] = 1'b0;
        if (cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL req_timeout port %0d addr %h got none required ready", p, a);
            sb_q[p].delete();
        end
    endtask

    task automatic test_reset();
        proc_reset = 1'b1;
        req_read   = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (3) @(negedge clk);
        proc_reset = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== '0) begin errors++;
            $display("FAIL reset_ready got %b required 0", req_ready); end
        checks++; if (mem_read !== 1'b0) begin errors++;
            $display("FAIL reset_mem_read got %b required 0", mem_read); end
        checks++; if (mem_write !== 1'b0) begin errors++;
            $display("FAIL reset_mem_write got %b required 0", mem_write); end
        checks++; if (hit_cnt !== '0) begin errors++;
            $display("FAIL reset_hit_cnt got %0d required 0", hit_cnt); end
        checks++; if (miss_cnt !== '0) begin errors++;
            $display("FAIL reset_miss_cnt got %0d required 0", miss_cnt); end
        checks++; if (req_rdata !== '0) begin errors++;
            $display("FAIL reset_rdata got %h required 0", req_rdata); end
    endtask

    task automatic test_cold_read();
        int cyc;
        mem_log.delete();
        mem_delay = 3;
        do_req(0, 1'b0, 28'h0000010, '0, cyc);
        checks++; if (cyc != 5) begin errors++;
            $display("FAIL cold_latency got %0d required 5", cyc); end
        checks++; if (mem_log.size() != 1 || mem_log[0].wr || mem_log[0].addr !== 28'h0000010)
            begin errors++;
            $display("FAIL cold_mem_ops got %0d ops required 1 read of 0x10", mem_log.size()); end
        checks++; if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin errors++;
            $display("FAIL cold_counters got hit %0d miss %0d required 0 1", hit_cnt, miss_cnt); end
    endtask

    task automatic test_hit();
        int cyc;
        mem_log.delete();
        do_req(1, 1'b0, 28'h0000010, '0, cyc);
        checks++; if (cyc != 2) begin errors++;
            $display("FAIL hit_latency got %0d required 2", cyc); end
        checks++; if (mem_log.size() != 0) begin errors++;
            $display("FAIL hit_mem_ops got %0d required 0", mem_log.size()); end
        checks++; if (hit_cnt !== 32'd1) begin errors++;
            $display("FAIL hit_cnt got %0d required 1", hit_cnt); end
    endtask

    task automatic test_writeback();
        int cyc;
        logic [LINE_W-1:0] wd;
        wd = 128'h1234;
        mem_log.delete();
        do_req(0, 1'b1, 28'h0000010, wd, cyc);
        checks++; if (cyc != 2) begin errors++;
            $display("FAIL wr_hit_latency got %0d required 2", cyc); end
        do_req(1, 1'b0, 28'h0000110, '0, cyc);
        checks++; if (cyc != 2 + 2 * mem_delay) begin errors++;
            $display("FAIL wb_latency got %0d required %0d", cyc, 2 + 2 * mem_delay); end
        checks++; if (mem_log.size() != 2) begin errors++;
            $display("FAIL wb_op_count got %0d required 2", mem_log.size()); end
        else begin
            checks++; if (!mem_log[0].wr || mem_log[0].addr !== 28'h0000010 ||
                          mem_log[0].data !== wd) begin errors++;
                $display("FAIL wb_write got wr %0d addr %h data %h required 1 10 %h",
                         mem_log[0].wr, mem_log[0].addr, mem_log[0].data, wd); end
            checks++; if (mem_log[1].wr || mem_log[1].addr !== 28'h0000110) begin errors++;
                $display("FAIL wb_fill got wr %0d addr %h required 0 110",
                         mem_log[1].wr, mem_log[1].addr); end
        end
        checks++; if (hit_cnt !== 32'd2 || miss_cnt !== 32'd2) begin errors++;
            $display("FAIL wb_counters got hit %0d miss %0d required 2 2", hit_cnt, miss_cnt); end
        mem_log.delete();
        do_req(0, 1'b0, 28'h0000010, '0, cyc);
        checks++; if (mem_log.size() != 1 || mem_log[0].wr) begin errors++;
            $display("FAIL clean_evict_ops got %0d required 1 read", mem_log.size()); end
        checks++; if (miss_cnt !== 32'd3) begin errors++;
            $display("FAIL reread_miss_cnt got %0d required 3", miss_cnt); end
    endtask

    task automatic test_write_miss();
        int cyc;
        mem_log.delete();
        do_req(0, 1'b1, 28'h0000025, 128'hFEED_0000_0000_0000_0000_0000_BEEF_0025, cyc);
        checks++; if (cyc != 2) begin errors++;
            $display("FAIL wmiss_latency got %0d required 2", cyc); end
        do_req(1, 1'b0, 28'h0000025, '0, cyc);
        checks++; if (cyc != 2) begin errors++;
            $display("FAIL wmiss_read_latency got %0d required 2", cyc); end
        checks++; if (mem_log.size() != 0) begin errors++;
            $display("FAIL wmiss_mem_ops got %0d required 0", mem_log.size()); end
        checks++; if (miss_cnt !== 32'd4 || hit_cnt !== 32'd3) begin errors++;
            $display("FAIL wmiss_counters got hit %0d miss %0d required 3 4", hit_cnt, miss_cnt); end
    endtask

    task automatic test_round_robin();
        int order[$];
        sb_t it;
        apply_reset();
        ref_mem.delete();
        mem_delay = 2;
        @(negedge clk);
        req_addr[0*ADDR_W +: ADDR_W] = 28'h0000030;
        req_addr[1*ADDR_W +: ADDR_W] = 28'h0000041;
        for (int k = 0; k < 3; k++) begin
            it.is_read = 1'b1;
            it.data = ref_read(28'h0000030); sb_q[0].push_back(it);
            it.data = ref_read(28'h0000041); sb_q[1].push_back(it);
        end
        req_read = 2'b11;
        for (int c = 0; c < 400 && order.size() < 6; c++) begin
            @(negedge clk);
            for (int p = 0; p < int'(NPORT); p++) if (req_ready[p]) order.push_back(p);
        end
        req_read = '0;
        checks++; if (order.size() != 6) begin errors++;
            $display("FAIL rr_count got %0d required 6", order.size()); end
        for (int i = 0; i < order.size(); i++) begin
            checks++; if (order[i] != i % 2) begin errors++;
                $display("FAIL rr_order[%0d] got %0d required %0d", i, order[i], i % 2); end
        end
        checks++; if (miss_cnt !== 32'd2 || hit_cnt !== 32'd4) begin errors++;
            $display("FAIL rr_counters got hit %0d miss %0d required 4 2", hit_cnt, miss_cnt); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit seen;
        mem_delay = 50;
        @(negedge clk);
        req_addr[0*ADDR_W +: ADDR_W] = 28'h0000052;
        req_read[0] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (mem_read) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++;
            $display("FAIL mid_alloc got no mem_read required 1"); end
        proc_reset  = 1'b1;
        req_read[0] = 1'b0;
        @(negedge clk);
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++;
            $display("FAIL mid_mem got rd %b wr %b required 0 0", mem_read, mem_write); end
        checks++; if (req_ready !== '0) begin errors++;
            $display("FAIL mid_ready got %b required 0", req_ready); end
        proc_reset = 1'b0;
        for (int p = 0; p < int'(NPORT); p++) sb_q[p].delete();
        mem_log.delete();
        mem_delay = 2;
        do_req(0, 1'b0, 28'h0000030, '0, cyc);
        checks++; if (cyc != 4) begin errors++;
            $display("FAIL post_reset_latency got %0d required 4", cyc); end
        checks++; if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin errors++;
            $display("FAIL post_reset_counters got hit %0d miss %0d required 0 1",
                     hit_cnt, miss_cnt); end
        checks++; if (mem_log.size() != 1 || mem_log[0].addr !== 28'h0000030) begin errors++;
            $display("FAIL post_reset_mem_ops got %0d ops required 1 read of 0x30",
                     mem_log.size()); end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_hit();
        test_writeback();
        test_write_miss();
        test_round_robin();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2cache_rr.md
Name: l2cache_rr

Overview:
- Parametrised successor to the two-port I/D L2: a unified, direct-mapped, write-back, write-allocate L2 shared by NPORT L1 requesters through one memory port.
- Adds round-robin arbitration so conflicting requesters never starve.
- Adds no-fetch install for full-line write misses.
- Adds saturating hit/miss performance counters.
- Sits between the L1 caches and main memory.

Parameters:
NPORT, 2, number of L1 requesters (port 0 = I, port 1 = D by convention); 2..8
ADDR_W, 28, line address width (one address = one LINE_W line)
LINE_W, 128, line data width
NSETS, 16, number of lines; power of two, >=2; index = addr[log2(NSETS)-1:0], tag = remaining upper bits
CNT_W, 32, performance counter width

Ports:
clk  input  1  clock
proc_reset  input  1  synchronous active-high reset
req_read  input  NPORT  per-port read request; held until that port's req_ready
req_write  input  NPORT  per-port full-line write request; held until req_ready
req_addr  input  NPORT*ADDR_W  packed per-port line address
req_wdata  input  NPORT*LINE_W  packed per-port write line
req_rdata  output  NPORT*LINE_W  packed per-port read line, valid when req_ready
req_ready  output  NPORT  one-cycle completion pulse per port
mem_read  output  1  memory line read
mem_write  output  1  memory line write
mem_addr  output  ADDR_W  memory line address
mem_wdata  output  LINE_W  memory write line
mem_rdata  input  LINE_W  memory read line, valid with mem_ready
mem_ready  input  1  memory completion; mem_read/mem_write held until it is seen
hit_cnt  output  CNT_W  saturating lookup-hit count
miss_cnt  output  CNT_W  saturating lookup-miss count

Behaviour:
- Storage: flop arrays valid[NSETS], dirty[NSETS], tag[NSETS], data[NSETS]; combinational read.
- Reset: state=IDLE; all valid/dirty=0; last_grant=NPORT-1; req_rdata=0; hit_cnt=miss_cnt=0.
- Reset also applies mid-transaction. req_ready, mem_read and mem_write are 0 from the cycle after the reset edge. An abandoned memory transaction is dropped.
- A port with both read and write asserted is treated as a write.
- FSM states: IDLE, LOOKUP, WRITEBACK, ALLOCATE, RESPOND.
- IDLE:
  - If any port requests, grant the first requester searching from last_grant+1 modulo NPORT.
  - Latch g, op, addr and wdata. Go to LOOKUP.
  - With no request, stay in IDLE.
- LOOKUP (hit = valid & tag match):
  - Read hit: req_rdata[g] <= line; hit_cnt++; go to RESPOND.
  - Write hit: line <= wdata, dirty <= 1; hit_cnt++; go to RESPOND.
  - Miss: miss_cnt++. If the victim is valid and dirty, go to WRITEBACK.
  - Clean read miss: go to ALLOCATE.
  - Clean write miss: install wdata with valid=1, dirty=1, new tag; go to RESPOND. No memory fetch.
- WRITEBACK:
  - Drive mem_write=1, mem_addr={victim tag,index}, mem_wdata=victim line.
  - On mem_ready: clear victim dirty. Read: go to ALLOCATE. Write: install as for a clean write miss, then go to RESPOND.
- ALLOCATE:
  - Drive mem_read=1, mem_addr=latched addr.
  - On mem_ready: fill with valid=1, dirty=0; req_rdata[g] <= mem_rdata; go to RESPOND. Counters are not re-incremented.
- RESPOND: req_ready[g]=1 for exactly this cycle; last_grant <= g; go to IDLE.
- Port outputs: req_rdata of other ports hold their values; mem_* signals are 0 outside WRITEBACK/ALLOCATE.
- Latency, counting the request-assert cycle as cycle 0 in IDLE:
  - hit: req_ready in cycle 2.
  - clean write miss: req_ready in cycle 2.
  - miss with memory: 2 + memory wait cycles per transaction.
- Counters: CNT_W-bit saturating at all-ones.
- Requesters deassert their request in the cycle after req_ready. A request still present in IDLE starts a new access.

Decomposition:
- Shared package l2_pkg holds:
  - state enum (IDLE/LOOKUP/WRITEBACK/ALLOCATE/RESPOND);
  - index/tag width functions (clog2-based);
  - default constants ADDR_W=28, LINE_W=128.
- One sub-module: rr_arbiter (NPORT request vector + last_grant -> one-hot grant + index), reusable elsewhere.

Test Plan:
- Cold read, port 0, addr 0x0000010 -> mem_read with mem_addr 0x0000010; memory returns 0xA5..A5 after 3 cycles -> req_ready[0] pulses with req_rdata[0]=0xA5..A5; miss_cnt=1.
- Repeat read, port 1, addr 0x0000010 -> req_ready[1] in cycle 2; no mem activity; hit_cnt=1.
- Write 0x1234 to 0x0000010 (hit), then read 0x0000110 (same index 0) -> mem_write at 0x0000010 with data 0x1234, then mem_read 0x0000110; returned line delivered.
- Write miss, clean set, addr 0x0000025 -> no mem_read; req_ready in cycle 2; later read hits with that data.
- Ports 0 and 1 request continuously after reset -> grants alternate 0,1,0,1; neither waits more than one transaction.
- proc_reset asserted during ALLOCATE -> mem_read=0 next cycle; state IDLE; previously valid line now misses.
